// File: rtl/noc_depacketizer.sv
// Receive-side NoC endpoint: checks the head flit of each ejected packet and
// streams its body/tail payload words to the local consumer with a last marker.
module noc_depacketizer #(
    parameter int                    FLIT_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] LOCAL_ADDR = 8'h00,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flit_valid,
    output logic                  flit_ready,
    input  logic [FLIT_WIDTH-1:0] flit_data,
    input  logic [1:0]            flit_type,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLIT_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  hdr_valid,
    output logic [ADDR_WIDTH-1:0] hdr_src,
    output logic [7:0]            hdr_len,
    output logic [7:0]            hdr_tag,
    output logic                  err_misroute,
    output logic                  err_len,
    output logic                  err_proto,
    output logic [7:0]            status,
    input  logic                  status_clr,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    localparam logic [1:0] FT_HEAD      = 2'b00;
    localparam logic [1:0] FT_BODY      = 2'b01;
    localparam logic [1:0] FT_TAIL      = 2'b10;
    localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

    localparam logic [7:0] STATUS_OK    = 8'h00;
    localparam logic [7:0] STATUS_BUSY  = 8'h01;
    localparam logic [7:0] STATUS_ERROR = 8'hFF;

    state_t                  state_r, state_nxt_s;
    logic [7:0]              rem_r, rem_nxt_s;
    logic                    out_valid_r, out_last_r;
    logic [FLIT_WIDTH-1:0]   out_data_r;
    logic                    hdr_valid_r;
    logic [ADDR_WIDTH-1:0]   hdr_src_r;
    logic [7:0]              hdr_len_r, hdr_tag_r;
    logic                    err_mis_r, err_len_r, err_proto_r;
    logic                    sticky_r;
    logic [CNT_WIDTH-1:0]    pkt_count_r;
    logic [7:0]              err_count_r;
    logic [7:0]              status_s;

    logic                    flit_ready_s, accept_s;
    logic                    fwd_s, fwd_last_s, hdr_take_s, pkt_done_s;
    logic                    mis_s, len_s, proto_s, err_any_s;
    logic [ADDR_WIDTH-1:0]   head_dest_s;
    logic [7:0]              head_len_s;

    assign head_dest_s = flit_data[31:24];
    assign head_len_s  = flit_data[15:8];
    assign accept_s    = flit_valid && flit_ready_s;
    assign err_any_s   = mis_s || len_s || proto_s;

    // Ejection backpressure: only PAYLOAD can be blocked by a full, stalled output register
    always_comb begin
        flit_ready_s = 1'b0;
        if (!rst_n) begin
            flit_ready_s = 1'b0;
        end else if (state_r == ST_PAYLOAD) begin
            flit_ready_s = !out_valid_r || out_ready;
        end else begin
            flit_ready_s = 1'b1;
        end
    end

    // Flit classification and next-state decode; at most one error class per flit
    always_comb begin
        state_nxt_s = state_r;
        rem_nxt_s   = rem_r;
        fwd_s       = 1'b0;
        fwd_last_s  = 1'b0;
        hdr_take_s  = 1'b0;
        pkt_done_s  = 1'b0;
        mis_s       = 1'b0;
        len_s       = 1'b0;
        proto_s     = 1'b0;
        if (accept_s) begin
            case (state_r)
                ST_IDLE: begin
                    if ((flit_type == FT_HEAD) || (flit_type == FT_HEAD_TAIL)) begin
                        if (head_dest_s != LOCAL_ADDR) begin
                            mis_s = 1'b1;
                            if (flit_type == FT_HEAD) begin
                                state_nxt_s = ST_DROP;
                            end else begin
                                state_nxt_s = ST_IDLE;
                            end
                        end else begin
                            hdr_take_s = 1'b1;
                            if ((flit_type == FT_HEAD) && (head_len_s != 8'd0)) begin
                                rem_nxt_s   = head_len_s;
                                state_nxt_s = ST_PAYLOAD;
                            end else if ((flit_type == FT_HEAD_TAIL) && (head_len_s == 8'd0)) begin
                                pkt_done_s = 1'b1;
                            end else begin
                                len_s = 1'b1;
                            end
                        end
                    end else begin
                        proto_s = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    if ((flit_type == FT_BODY) || (flit_type == FT_TAIL)) begin
                        fwd_s     = 1'b1;
                        rem_nxt_s = rem_r - 8'd1;
                        if (flit_type == FT_TAIL) begin
                            fwd_last_s  = 1'b1;
                            state_nxt_s = ST_IDLE;
                            if (rem_r == 8'd1) begin
                                pkt_done_s = 1'b1;
                            end else begin
                                len_s = 1'b1;
                            end
                        end else if (rem_r == 8'd1) begin
                            // Length exhausted before the tail: close the word stream, drop the rest
                            fwd_last_s  = 1'b1;
                            len_s       = 1'b1;
                            state_nxt_s = ST_DROP;
                        end else begin
                            fwd_last_s = 1'b0;
                        end
                    end else begin
                        proto_s = 1'b1;
                    end
                end
                ST_DROP: begin
                    if ((flit_type == FT_TAIL) || (flit_type == FT_HEAD_TAIL)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM, output register, header latch, pulses and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rem_r       <= 8'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            hdr_valid_r <= 1'b0;
            hdr_src_r   <= '0;
            hdr_len_r   <= 8'd0;
            hdr_tag_r   <= 8'd0;
            err_mis_r   <= 1'b0;
            err_len_r   <= 1'b0;
            err_proto_r <= 1'b0;
            sticky_r    <= 1'b0;
            pkt_count_r <= '0;
            err_count_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
            if (fwd_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= flit_data;
                out_last_r  <= fwd_last_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
            hdr_valid_r <= hdr_take_s;
            if (hdr_take_s) begin
                hdr_src_r <= flit_data[23:16];
                hdr_len_r <= head_len_s;
                hdr_tag_r <= flit_data[7:0];
            end
            err_mis_r   <= mis_s;
            err_len_r   <= len_s;
            err_proto_r <= proto_s;
            if (err_any_s) begin
                sticky_r <= 1'b1;
            end else if (status_clr) begin
                sticky_r <= 1'b0;
            end
            if (err_any_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end
            if (pkt_done_s && (pkt_count_r != {CNT_WIDTH{1'b1}})) begin
                pkt_count_r <= pkt_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Status code decode, error taking precedence over activity
    always_comb begin
        status_s = STATUS_OK;
        if (sticky_r) begin
            status_s = STATUS_ERROR;
        end else if ((state_r != ST_IDLE) || out_valid_r) begin
            status_s = STATUS_BUSY;
        end else begin
            status_s = STATUS_OK;
        end
    end

    assign flit_ready   = flit_ready_s;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_last     = out_last_r;
    assign hdr_valid    = hdr_valid_r;
    assign hdr_src      = hdr_src_r;
    assign hdr_len      = hdr_len_r;
    assign hdr_tag      = hdr_tag_r;
    assign err_misroute = err_mis_r;
    assign err_len      = err_len_r;
    assign err_proto    = err_proto_r;
    assign status       = status_s;
    assign pkt_count    = pkt_count_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_noc_depacketizer.sv
// Directed bench for noc_depacketizer: a packet-level reference model checked
// every cycle, plus hand-computed expectations at the end of each scenario.
module tb_noc_depacketizer;

    localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HT = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n, flit_valid, flit_ready, out_valid, out_ready, out_last;
    logic [31:0] flit_data, out_data;
    logic [1:0]  flit_type;
    logic        hdr_valid, err_misroute, err_len, err_proto, status_clr;
    logic [7:0]  hdr_src, hdr_len, hdr_tag, status, err_count;
    logic [15:0] pkt_count;

    noc_depacketizer dut (
        .clk(clk), .rst_n(rst_n), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .flit_data(flit_data), .flit_type(flit_type), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .hdr_valid(hdr_valid), .hdr_src(hdr_src), .hdr_len(hdr_len), .hdr_tag(hdr_tag),
        .err_misroute(err_misroute), .err_len(err_len), .err_proto(err_proto),
        .status(status), .status_clr(status_clr), .pkt_count(pkt_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Packet-level reference: mode 0 = waiting for head, 1 = in packet, 2 = discarding
    int          m_mode;
    int          m_rem;
    bit          m_ov, m_ol, m_hv, m_em, m_el, m_ep, m_sticky, m_acc;
    logic [31:0] m_od;
    logic [7:0]  m_src, m_len, m_tag, m_ec;
    logic [15:0] m_pc;

    logic [32:0] rx_q[$];
    bit          rq[$];
    int          n_hdr, n_mis, n_len, n_proto, n_hold;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_ov = 1'b0; m_ol = 1'b0; m_od = 32'h0;
        m_hv = 1'b0; m_em = 1'b0; m_el = 1'b0; m_ep = 1'b0; m_sticky = 1'b0; m_acc = 1'b0;
        m_src = 8'h0; m_len = 8'h0; m_tag = 8'h0; m_ec = 8'h0; m_pc = 16'h0;
    endtask

    function automatic bit model_ready();
        if (!rst_n) return 1'b0;
        if (m_mode == 1) return (!m_ov || out_ready);
        return 1'b1;
    endfunction

    // Applies the packet rules to the flit presented before this edge
    task automatic model_update();
        logic [7:0] dst, ln;
        m_hv = 1'b0; m_em = 1'b0; m_el = 1'b0; m_ep = 1'b0; m_acc = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_acc = flit_valid && model_ready();
        if (m_ov && out_ready) m_ov = 1'b0;
        if (m_acc) begin
            dst = flit_data[31:24];
            ln  = flit_data[15:8];
            if (m_mode == 0) begin
                if (flit_type == HEAD || flit_type == HT) begin
                    if (dst != 8'h00) begin
                        m_em = 1'b1;
                        if (flit_type == HEAD) m_mode = 2;
                    end else begin
                        m_hv = 1'b1; m_src = flit_data[23:16]; m_len = ln; m_tag = flit_data[7:0];
                        if (flit_type == HEAD && ln != 8'd0) begin
                            m_rem = ln; m_mode = 1;
                        end else if (flit_type == HT && ln == 8'd0) begin
                            if (m_pc != 16'hFFFF) m_pc++;
                        end else m_el = 1'b1;
                    end
                end else m_ep = 1'b1;
            end else if (m_mode == 1) begin
                if (flit_type == BODY || flit_type == TAIL) begin
                    m_ov = 1'b1; m_od = flit_data;
                    m_ol = (flit_type == TAIL) || (m_rem == 1);
                    if (flit_type == TAIL) begin
                        m_mode = 0;
                        if (m_rem == 1) begin
                            if (m_pc != 16'hFFFF) m_pc++;
                        end else m_el = 1'b1;
                    end else if (m_rem == 1) begin
                        m_el = 1'b1; m_mode = 2;
                    end
                    m_rem = m_rem - 1;
                end else m_ep = 1'b1;
            end else begin
                if (flit_type == TAIL || flit_type == HT) m_mode = 0;
            end
        end
        if (m_em || m_el || m_ep) begin
            m_sticky = 1'b1;
            if (m_ec != 8'hFF) m_ec++;
        end else if (status_clr) m_sticky = 1'b0;
    endtask

    // Per-cycle comparison of every DUT output against the reference
    always @(negedge clk) begin
        logic [7:0] exp_status;
        exp_status = m_sticky ? 8'hFF : ((m_mode != 0 || m_ov) ? 8'h01 : 8'h00);
        chk("flit_ready", {31'h0, flit_ready}, {31'h0, model_ready()});
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_last", {31'h0, out_last}, {31'h0, m_ol});
        end
        chk("hdr_valid", {31'h0, hdr_valid}, {31'h0, m_hv});
        chk("hdr_fields", {8'h0, hdr_src, hdr_len, hdr_tag}, {8'h0, m_src, m_len, m_tag});
        chk("err_pulses", {29'h0, err_misroute, err_len, err_proto}, {29'h0, m_em, m_el, m_ep});
        chk("status", {24'h0, status}, {24'h0, exp_status});
        chk("pkt_count", {16'h0, pkt_count}, {16'h0, m_pc});
        chk("err_count", {24'h0, err_count}, {24'h0, m_ec});
        if (out_valid && out_ready) rx_q.push_back({out_last, out_data});
        if (hdr_valid) n_hdr++;
        if (err_misroute) n_mis++;
        if (err_len) n_len++;
        if (err_proto) n_proto++;
        if (out_valid && !out_ready && !flit_ready) n_hold++;
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        if (rq.size() > 0) out_ready = rq.pop_front();
        else out_ready = 1'b1;
    endtask

    task automatic send(input logic [1:0] ty, input logic [31:0] d);
        bit done;
        done = 1'b0;
        flit_valid = 1'b1; flit_type = ty; flit_data = d;
        for (int k = 0; k < 20 && !done; k++) begin
            step();
            done = m_acc;
        end
        if (!done) chk("send_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle(input int n);
        flit_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic chk_rx(input string nm, input int idx, input logic [32:0] exp);
        if (idx < rx_q.size()) chk(nm, rx_q[idx][31:0] ^ {31'h0, rx_q[idx][32]}, exp[31:0] ^ {31'h0, exp[32]});
        else chk(nm, 32'hDEAD_0000, exp[31:0]);
    endtask

    initial begin
        int hdr0;
        rst_n = 1'b0; flit_valid = 1'b0; flit_type = 2'b00; flit_data = 32'h0;
        out_ready = 1'b1; status_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_flit_ready", {31'h0, flit_ready}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_status", {24'h0, status}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: clean three-word packet
        rx_q.delete();
        send(HEAD, 32'h0005_03A1); send(BODY, 32'h11); send(BODY, 32'h22); send(TAIL, 32'h33);
        idle(3);
        chk("t1_words", rx_q.size(), 32'd3);
        chk_rx("t1_w0", 0, {1'b0, 32'h11});
        chk_rx("t1_w1", 1, {1'b0, 32'h22});
        chk_rx("t1_w2", 2, {1'b1, 32'h33});
        chk("t1_hdr", {8'h0, hdr_src, hdr_len, hdr_tag}, 32'h0005_03A1);
        chk("t1_hdr_pulses", n_hdr, 32'd1);
        chk("t1_pkt_count", {16'h0, pkt_count}, 32'd1);
        chk("t1_status", {24'h0, status}, 32'h00);

        // 2: same packet under consumer backpressure
        rx_q.delete(); n_hold = 0;
        rq = '{1'b1, 1'b0, 1'b0, 1'b1};
        send(HEAD, 32'h0005_03A1); send(BODY, 32'h11); send(BODY, 32'h22); send(TAIL, 32'h33);
        idle(3);
        chk("t2_words", rx_q.size(), 32'd3);
        chk_rx("t2_w0", 0, {1'b0, 32'h11});
        chk_rx("t2_w1", 1, {1'b0, 32'h22});
        chk_rx("t2_w2", 2, {1'b1, 32'h33});
        chk("t2_stall_cycles", n_hold, 32'd2);
        chk("t2_pkt_count", {16'h0, pkt_count}, 32'd2);

        // 3: misrouted packet is dropped, then the sticky error is cleared
        rx_q.delete(); hdr0 = n_hdr;
        send(HEAD, 32'h0705_02B2); send(BODY, 32'h5A); send(TAIL, 32'h5B);
        idle(2);
        chk("t3_misroute", n_mis, 32'd1);
        chk("t3_no_words", rx_q.size(), 32'd0);
        chk("t3_no_hdr", n_hdr - hdr0, 32'd0);
        chk("t3_status_err", {24'h0, status}, 32'hFF);
        chk("t3_err_count", {24'h0, err_count}, 32'd1);
        status_clr = 1'b1; step(); status_clr = 1'b0;
        chk("t3_status_clr", {24'h0, status}, 32'h00);

        // 4: tail arrives before the declared length
        rx_q.delete();
        send(HEAD, 32'h0005_03C4); send(BODY, 32'h44); send(TAIL, 32'h55);
        idle(3);
        chk("t4_words", rx_q.size(), 32'd2);
        chk_rx("t4_w1_last", 1, {1'b1, 32'h55});
        chk("t4_err_len", n_len, 32'd1);
        chk("t4_pkt_count", {16'h0, pkt_count}, 32'd2);
        chk("t4_status", {24'h0, status}, 32'hFF);

        // 5: stray body, then header-only packets
        send(BODY, 32'h66); idle(1);
        chk("t5_err_proto", n_proto, 32'd1);
        send(HT, 32'h0009_00D5); idle(2);
        chk("t5_pkt_count", {16'h0, pkt_count}, 32'd3);
        chk("t5_hdr", {8'h0, hdr_src, hdr_len, hdr_tag}, 32'h0009_00D5);
        send(HT, 32'h0009_02E6); idle(2);
        chk("t5_ht_len_err", n_len, 32'd2);
        chk("t5_err_count", {24'h0, err_count}, 32'd4);

        // 6: reset in the middle of a packet, then a fresh packet
        send(HEAD, 32'h0003_04F7); send(BODY, 32'h77); send(BODY, 32'h88);
        flit_valid = 1'b0;
        rst_n = 1'b0; model_reset();
        #1;
        chk("t6_rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("t6_rst_status", {24'h0, status}, 32'h00);
        chk("t6_rst_hdr_src", {24'h0, hdr_src}, 32'h0);
        step(); step();
        rst_n = 1'b1;
        rx_q.delete();
        send(HEAD, 32'h0003_02A8); send(BODY, 32'h99); send(TAIL, 32'hAA);
        idle(3);
        chk("t6_words", rx_q.size(), 32'd2);
        chk_rx("t6_w0", 0, {1'b0, 32'h99});
        chk_rx("t6_w1", 1, {1'b1, 32'hAA});
        chk("t6_pkt_count", {16'h0, pkt_count}, 32'd1);
        chk("t6_err_count", {24'h0, err_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
